alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, for example the integer pipeline issue port and the multicycle mul/div sequencer.
- Arbitrates round-robin, latches the winning operands, drives them onto the ALU for a configurable settle time, then captures result and carry-out.
- Returns result, carry-out and requester id over a valid/ready response channel.
- Sits between the requesters and the ALU instance. Only this block drives ALU inputs.

Parameters:
- ALU_WAIT, 1, number of cycles the ALU inputs are held before capture (legal range 1..15; covers the ALU's internal #1 delays at any clock).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  operand a.
- req0_b  in  32  operand b.
- req0_alucont  in  6  ALU control code.
- req1_valid / req1_ready / req1_a / req1_b / req1_alucont  same as requester 0, for requester 1.
- alu_a  out  32  to ALU operand a.
- alu_b  out  32  to ALU operand b.
- alu_alucont  out  6  to ALU control.
- alu_result  in  32  from ALU.
- alu_overflow  in  1  carry-out from ALU.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  32  captured result.
- rsp_overflow  out  1  captured carry-out.
- rsp_id  out  1  requester that issued the operation.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all ready outputs, rsp_valid and busy are 0.
  - rsp_result=0, rsp_overflow=0, rsp_id=0.
  - alu_a=0, alu_b=0, alu_alucont=0; wait counter=0.
  - Priority pointer favours requester 0.
- State IDLE:
  - reqN_ready is combinational: 1 only for the granted requester while in IDLE with that valid high. Never both at once.
  - Grant rule:
    - Only one valid: that requester wins.
    - Both valid: the requester not granted last wins (req0 after reset).
  - On grant edge:
    - latch a, b, alucont into alu_a/alu_b/alu_alucont registers;
    - record id; set pointer to the other requester;
    - load counter=ALU_WAIT-1; go to EXEC.
- State EXEC:
  - ALU inputs held stable from the registers.
  - While counter != 0: decrement each cycle.
  - At counter==0: on that edge capture alu_result → rsp_result, alu_overflow → rsp_overflow, latched id → rsp_id; go to RESP.
- State RESP:
  - rsp_valid=1; rsp_result, rsp_overflow and rsp_id are held stable.
  - On rsp_valid & rsp_ready: rsp_valid drops the next cycle and the state returns to IDLE.
- Timing and throughput:
  - Latency: accept edge k → rsp_valid high after edge k+ALU_WAIT.
  - One IDLE cycle minimum between operations. Peak throughput is one op per ALU_WAIT+2 cycles.
  - ALU inputs keep the last operands outside EXEC; they are not cleared.
- Requester rules:
  - Must hold valid and operands stable until ready.
  - Deasserting valid before ready is allowed; nothing is issued.
  - Requests arriving in EXEC/RESP wait. Their ready stays 0.
- Backpressure: rsp_ready low for any duration keeps RESP; no new grant occurs.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and the pointer returns to requester 0.
- Arithmetic: none in this block. The ALU defines results; the block passes alucont through unmodified.

Test Plan:
- ALU_WAIT=1; req0 add (alucont 000010) a=5, b=7, rsp_ready=1
  → req0_ready pulses 1 cycle; rsp_valid after 1 more edge; rsp_result=12, overflow=0, id=0.
- After reset, both valid: req0 AND 0x0000F0F0 & 0x00000FF0, req1 sub (100010) 3-5
  → req0 first, result 0x000000F0;
  → then req1, result 0xFFFFFFFE, overflow 0, id=1;
  → both valid again → req0 granted.
- req1 add 0xFFFFFFFF+1 → rsp_result=0, rsp_overflow=1.
- rsp_ready held 0 for 5 cycles with req0 valid
  → rsp_valid and outputs stable all 5 cycles; req0_ready stays 0;
  → raising rsp_ready drains the response, and req0 is granted 1 cycle later.
- ALU_WAIT=3; slt (100011) a=2, b=9 → rsp_valid after edge k+3, result=1; alu_a/alu_b are stable throughout EXEC.
- reset_n pulsed low during EXEC → all outputs at reset values immediately; no rsp_valid afterwards; next simultaneous request grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// The winning operands are held on the ALU for ALU_WAIT cycles, then the result is returned over valid/ready.
module alu_arbiter #(
  parameter int unsigned ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_alucont,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_alucont,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_alucont,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] WAIT_M1 = 4'(ALU_WAIT - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [5:0]  alu_c_q, alu_c_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_overflow_q, rsp_overflow_d;
  logic        rsp_id_q, rsp_id_d;
  logic        gnt_id;

  // ptr_q = 1 means requester 1 has priority on a tie
  assign gnt_id = (req0_valid && req1_valid) ? ptr_q : req1_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= 1'b0;
      cnt_q          <= 4'd0;
      id_q           <= 1'b0;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_c_q        <= 6'd0;
      rsp_result_q   <= 32'd0;
      rsp_overflow_q <= 1'b0;
      rsp_id_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      id_q           <= id_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_c_q        <= alu_c_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_id_q       <= rsp_id_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    id_d           = id_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_c_d        = alu_c_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_id_d       = rsp_id_q;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = !gnt_id;
          req1_ready = gnt_id;
          alu_a_d    = gnt_id ? req1_a : req0_a;
          alu_b_d    = gnt_id ? req1_b : req0_b;
          alu_c_d    = gnt_id ? req1_alucont : req0_alucont;
          id_d       = gnt_id;
          ptr_d      = !gnt_id;
          cnt_d      = WAIT_M1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d   = alu_result;
          rsp_overflow_d = alu_overflow;
          rsp_id_d       = id_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_alucont  = alu_c_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);

endmodule
